// File: rtl/boot_loader_mem_pkg.sv
// Shared types and defaults for the boot loader memory block.
// Defaults match the control unit's 16-bit datalines and 8-bit adlines.
package boot_loader_mem_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int ADDR_W_DEF     = 8;
  localparam int START_ADDR_DEF = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_RUN,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/boot_loader_mem_ram_sp.sv
// Single-port RAM: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module ram_sp #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/boot_loader_mem.sv
// Program RAM plus load sequencer feeding the control unit.
// Optional trailing checksum word enabled by `define BOOT_LOADER_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for load_start
// LOAD  | accepting program words into RAM
// CHECK | accepting the checksum word (checksum build only)
// RUN   | control unit enabled, serving its bus
// ERROR | checksum mismatch, waiting for reset or a new load_start
module boot_loader_mem
  import boot_loader_mem_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int START_ADDR = START_ADDR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_len,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_error,
  output logic              enable,
  input  logic [ADDR_W-1:0] addressbus,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] toram,
  output logic [DATA_W-1:0] fromram
);

  localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);

  state_e            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_len;
  logic              r_ready;
  logic              r_done;
  logic              r_enable;
  logic              r_error;

  logic              w_accept;
  logic              w_cu_we;
  logic              w_we;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_unused_read;

  // Reads need no strobe; fromram is always mem[addressbus].
  assign w_unused_read = read;

  assign w_accept  = (r_state == ST_LOAD) && r_ready && load_valid;
  assign w_cu_we   = (r_state == ST_RUN) && write;
  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_we      = w_accept | w_cu_we;
  assign w_waddr   = w_accept ? (START_A + r_cnt) : addressbus;
  assign w_wdata   = w_accept ? load_data : toram;

`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum <= '0;
    end else if ((r_state == ST_IDLE || r_state == ST_ERROR) && load_start) begin
      r_sum <= '0;
    end else if (w_accept) begin
      r_sum <= r_sum + load_data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_len    <= '0;
      r_ready  <= 1'b0;
      r_done   <= 1'b0;
      r_enable <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (load_start) begin
            r_cnt <= '0;
            r_len <= load_len;
            if (load_len != '0) begin
              r_state <= ST_LOAD;
              r_ready <= 1'b1;
            end else begin
`ifdef BOOT_LOADER_CHECKSUM_EN
              r_state <= ST_CHECK;
              r_ready <= 1'b1;
`else
              r_state  <= ST_RUN;
              r_enable <= 1'b1;
              r_done   <= 1'b1;
`endif
            end
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == r_len) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
              r_state <= ST_CHECK;
`else
              r_state  <= ST_RUN;
              r_ready  <= 1'b0;
              r_enable <= 1'b1;
              r_done   <= 1'b1;
`endif
            end
          end
        end
`ifdef BOOT_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (load_valid) begin
            r_ready <= 1'b0;
            if (load_data == r_sum) begin
              r_state  <= ST_RUN;
              r_enable <= 1'b1;
              r_done   <= 1'b1;
            end else begin
              r_state <= ST_ERROR;
              r_error <= 1'b1;
            end
          end
        end
        ST_ERROR: begin
          if (load_start) begin
            r_cnt   <= '0;
            r_len   <= load_len;
            r_error <= 1'b0;
            r_ready <= 1'b1;
            r_state <= (load_len != '0) ? ST_LOAD : ST_CHECK;
          end
        end
`endif
        ST_RUN: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  ram_sp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (addressbus),
    .o_rdata (fromram)
  );

  assign load_ready = r_ready;
  assign load_done  = r_done;
  assign enable     = r_enable;
  assign load_error = r_error;

endmodule
